fetch_sequencer: RTL and testbench

//  Program-counter sequencer for the 256x16 instruction memory: drives address/fetch_en, registers
//  the fetched word into a one-entry IF output stage with valid/ready backpressure, and pre-decodes
//  J-type CALL/RET against an internal return-address stack (RAS). Execute-stage branch redirects

---
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer for the instruction memory.
// Drives the fetch address and enable. Captures the fetched word into a
// one-entry IF register that supports valid/ready backpressure. Pre-decodes
// CALL/RET against a circular return-address stack. Execute-stage redirects
// take priority over all other sequencing.
module fetch_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = {{(ADDR_W-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_fetch_en,
  input  logic [15:0]       imem_instr,
  output logic              if_valid,
  output logic [15:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_if_valid;
  logic [15:0]       r_if_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic [PTR_W-1:0]  r_ras_ptr;   // next slot to write; the top of stack is the slot just below it
  logic [CNT_W-1:0]  r_ras_cnt;
  logic              r_ras_overflow;
  logic              r_ras_underflow;
  logic [ADDR_W-1:0] r_ras_mem [RAS_DEPTH];

  logic              w_redirect;
  logic              w_fire;
  logic              w_is_j;
  logic              w_call;
  logic              w_ret;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic              w_push;
  logic              w_pop;
  logic              w_ret_empty;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_ras_top;
  logic [ADDR_W-1:0] w_next_pc;
  logic [PTR_W-1:0]  w_ptr_inc;
  logic [PTR_W-1:0]  w_ptr_dec;

  // A redirect during BOOT is ignored. In any other state it flushes and wins over fetch.
  assign w_redirect = br_taken && (r_state != ST_BOOT);
  assign w_fire     = (r_state == ST_RUN) && (!r_if_valid || if_ready) && !br_taken;

  assign w_is_j = (imem_instr[15:12] == 4'b0001);
  assign w_call = w_is_j && (imem_instr[2:0] == 3'b001);
  assign w_ret  = w_is_j && (imem_instr[2:0] == 3'b010);

  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ras_full  = (r_ras_cnt == CNT_W'(RAS_DEPTH));
  assign w_push      = w_fire && w_call;
  assign w_pop       = w_fire && w_ret && !w_ras_empty;
  assign w_ret_empty = w_fire && w_ret && w_ras_empty;

  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_ptr_inc = (r_ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + PTR_W'(1);
  assign w_ptr_dec = (r_ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_ras_ptr - PTR_W'(1);
  assign w_ras_top = r_ras_mem[w_ptr_dec];

  // Select the next PC from the word being fetched: CALL target, RAS top, or sequential.
  always_comb begin
    // NOTE: assign a default first so that no path through the block leaves the value unassigned and infers a latch.
    w_next_pc = w_pc_inc;
    if (w_call) begin
      w_next_pc = {r_pc[ADDR_W-1:9], imem_instr[11:3]};
    end else if (w_ret && !w_ras_empty) begin
      w_next_pc = w_ras_top;
    end
  end

  // FSM, PC, IF output register, RAS bookkeeping and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state         <= ST_BOOT;
      r_pc            <= RESET_PC;
      r_if_valid      <= 1'b0;
      r_if_instr      <= '0;
      r_if_pc         <= '0;
      r_ras_ptr       <= '0;
      r_ras_cnt       <= '0;
      r_ras_overflow  <= 1'b0;
      r_ras_underflow <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= br_target;
      r_if_valid <= 1'b0;
      r_state    <= ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN:  if (w_ret_empty) r_state <= ST_HALT;
        default: r_state <= r_state;
      endcase

      if (w_fire) begin
        r_if_instr <= imem_instr;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b1;
        r_pc       <= w_next_pc;
      end else if (r_if_valid && if_ready) begin
        r_if_valid <= 1'b0;
      end

      if (w_push) begin
        r_ras_ptr <= w_ptr_inc;
        if (w_ras_full) begin
          r_ras_overflow <= 1'b1;
        end else begin
          r_ras_cnt <= r_ras_cnt + CNT_W'(1);
        end
      end else if (w_pop) begin
        r_ras_ptr <= w_ptr_dec;
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end

      if (w_ret_empty) begin
        r_ras_underflow <= 1'b1;
      end
    end
  end

  // Return-address storage. When the stack is full, a push lands on the oldest entry.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. The count and pointer make stale entries unreachable.
    if (w_push) begin
      r_ras_mem[r_ras_ptr] <= w_pc_inc;
    end
  end

  assign imem_addr     = r_pc;
  assign imem_fetch_en = w_fire;
  assign if_valid      = r_if_valid;
  assign if_instr      = r_if_instr;
  assign if_pc         = r_if_pc;
  assign ras_overflow  = r_ras_overflow;
  assign ras_underflow = r_ras_underflow;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed test of fetch_sequencer with a 256-word memory model.
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// or 1 time unit after an input change when the output is combinational.
module tb_fetch_sequencer;

  localparam int ADDR_W = 16;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_fetch_en;
  logic [15:0]       imem_instr;
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_ready;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              ras_overflow;
  logic              ras_underflow;

  logic [15:0] mem [256];
  logic        addr0_seen;
  int          checks;
  int          errors;

  fetch_sequencer #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(2),
    .RESET_PC (16'h0001)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_fetch_en(imem_fetch_en),
    .imem_instr   (imem_instr),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_ready     (if_ready),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  assign imem_instr = mem[imem_addr[7:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record any fetch from the reserved word 0. This runs before the wrap test only.
  always @(posedge clk) begin
    if (rst_n && imem_fetch_en && imem_addr == 16'h0000) addr0_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    addr0_seen = 1'b0;
    rst_n      = 1'b0;
    if_ready   = 1'b1;
    br_taken   = 1'b0;
    br_target  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h3000 | 16'(i);
    mem[0]    = 16'h0000;
    mem[8'h07] = 16'h1049;  // CALL 9
    mem[8'h0A] = 16'h1002;  // RET
    mem[8'h21] = 16'h1201;  // CALL 0x40, redirected away
    mem[8'h50] = 16'h1301;  // CALL 0x60
    mem[8'h60] = 16'h1381;  // CALL 0x70
    mem[8'h70] = 16'h1401;  // CALL 0x80
    mem[8'h80] = 16'h1002;  // RET
    mem[8'h71] = 16'h1002;  // RET
    mem[8'h61] = 16'h1002;  // RET (empty stack)

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(if_valid), 0);
    check("rst_addr", 32'(imem_addr), 32'h0001);
    check("rst_fetch_en", 32'(imem_fetch_en), 0);
    check("rst_if_pc", 32'(if_pc), 0);
    check("rst_if_instr", 32'(if_instr), 0);
    check("rst_ovf", 32'(ras_overflow), 0);
    check("rst_unf", 32'(ras_underflow), 0);

    // Test 1: boot, then sequential fetch.
    rst_n = 1'b1;
    tick();
    check("boot_valid", 32'(if_valid), 0);
    check("boot_fetch_en", 32'(imem_fetch_en), 1);
    check("boot_addr", 32'(imem_addr), 32'h0001);
    tick();
    check("seq1_valid", 32'(if_valid), 1);
    check("seq1_pc", 32'(if_pc), 32'h0001);
    check("seq1_instr", 32'(if_instr), 32'h3001);
    tick();
    check("seq2_pc", 32'(if_pc), 32'h0002);
    tick();
    check("seq3_pc", 32'(if_pc), 32'h0003);
    check("seq3_addr", 32'(imem_addr), 32'h0004);

    // Test 2: stall for 3 clocks.
    if_ready = 1'b0;
    #1;
    check("stall_fetch_en", 32'(imem_fetch_en), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(if_pc), 32'h0003);
      check("stall_instr", 32'(if_instr), 32'h3003);
      check("stall_addr", 32'(imem_addr), 32'h0004);
      check("stall_valid", 32'(if_valid), 1);
    end
    if_ready = 1'b1;
    tick();
    check("resume_pc", 32'(if_pc), 32'h0004);
    tick();
    tick();
    check("pre_call_pc", 32'(if_pc), 32'h0006);

    // Test 3: CALL at 7 to 9, RET at 10 back to 8.
    tick();
    check("call_instr", 32'(if_instr), 32'h1049);
    check("call_addr", 32'(imem_addr), 32'h0009);
    check("call_cnt", 32'(dut.r_ras_cnt), 1);
    tick();
    check("call_tgt_pc", 32'(if_pc), 32'h0009);
    tick();
    check("ret_pc", 32'(if_pc), 32'h000A);
    check("ret_addr", 32'(imem_addr), 32'h0008);
    check("ret_cnt", 32'(dut.r_ras_cnt), 0);
    tick();
    check("ret_tgt_pc", 32'(if_pc), 32'h0008);

    // Test 4: redirect while stalled, then redirect over a CALL.
    if_ready = 1'b0;
    tick();
    br_taken  = 1'b1;
    br_target = 16'h0020;
    #1;
    check("br_fetch_en", 32'(imem_fetch_en), 0);
    tick();
    check("br_flush_valid", 32'(if_valid), 0);
    check("br_addr", 32'(imem_addr), 32'h0020);
    br_taken = 1'b0;
    if_ready = 1'b1;
    tick();
    check("br_tgt_pc", 32'(if_pc), 32'h0020);
    check("br_call_addr", 32'(imem_addr), 32'h0021);
    br_taken  = 1'b1;
    br_target = 16'h0030;
    tick();
    check("br_call_cnt", 32'(dut.r_ras_cnt), 0);
    check("br_call_addr2", 32'(imem_addr), 32'h0030);
    check("br_call_valid", 32'(if_valid), 0);
    br_taken = 1'b0;
    tick();
    check("br_call_pc", 32'(if_pc), 32'h0030);

    // Test 5: overflow with 3 nested calls, then underflow and HALT.
    br_taken  = 1'b1;
    br_target = 16'h0050;
    tick();
    br_taken = 1'b0;
    tick();
    check("nest1_pc", 32'(if_pc), 32'h0050);
    check("nest1_ovf", 32'(ras_overflow), 0);
    tick();
    check("nest2_pc", 32'(if_pc), 32'h0060);
    check("nest2_ovf", 32'(ras_overflow), 0);
    tick();
    check("nest3_pc", 32'(if_pc), 32'h0070);
    check("nest3_ovf", 32'(ras_overflow), 1);
    check("nest3_cnt", 32'(dut.r_ras_cnt), 2);
    check("nest3_addr", 32'(imem_addr), 32'h0080);
    tick();
    check("ret1_addr", 32'(imem_addr), 32'h0071);
    tick();
    check("ret2_addr", 32'(imem_addr), 32'h0061);
    check("ret2_unf", 32'(ras_underflow), 0);
    tick();
    check("ret3_instr", 32'(if_instr), 32'h1002);
    check("ret3_pc", 32'(if_pc), 32'h0061);
    check("ret3_unf", 32'(ras_underflow), 1);
    check("ret3_addr", 32'(imem_addr), 32'h0062);
    check("halt_fetch_en", 32'(imem_fetch_en), 0);
    tick();
    check("halt_valid", 32'(if_valid), 0);
    check("halt_fetch_en2", 32'(imem_fetch_en), 0);
    tick();
    check("halt_fetch_en3", 32'(imem_fetch_en), 0);
    br_taken  = 1'b1;
    br_target = 16'h0001;
    tick();
    br_taken = 1'b0;
    #1;
    check("restart_addr", 32'(imem_addr), 32'h0001);
    check("restart_fetch_en", 32'(imem_fetch_en), 1);
    tick();
    check("restart_pc", 32'(if_pc), 32'h0001);
    check("no_addr0", 32'(addr0_seen), 0);

    // Test 6: asynchronous reset during a stall, then PC wrap.
    if_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(if_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(if_valid), 0);
    check("arst_addr", 32'(imem_addr), 32'h0001);
    check("arst_if_pc", 32'(if_pc), 0);
    check("arst_ovf", 32'(ras_overflow), 0);
    check("arst_unf", 32'(ras_underflow), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    if_ready = 1'b1;
    tick();
    br_taken  = 1'b1;
    br_target = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    #1;
    check("wrap_addr_ffff", 32'(imem_addr), 32'hFFFF);
    tick();
    check("wrap_pc", 32'(if_pc), 32'hFFFF);
    check("wrap_addr", 32'(imem_addr), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
